mc_ctrl_seq: RTL and testbench
==============================

// Module: mc_ctrl_seq
// PURPOSE
//   Multi-cycle control sequencer driving the FullDMRFALU datapath control interface.
//   Accepts one 32-bit MIPS-format instruction via a valid/ready handshake.
//   Splits it into register fields and the sign-extend input.
//   Steps the datapath through DECODE/EXEC/MEM/WB, pulsing write/read strobes at the right cycle.
// PARAMETERS
//   MEM_WAIT  1  cycles spent in MEM state (data-memory latency), legal 1..15
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   instr        in   32  instruction word: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm, [5:0] funct
//   instr_valid  in   1   instr holds a valid instruction
//   instr_ready  out  1   sequencer idle and able to accept
//   Zero         in   1   ALU zero flag from datapath
//   rs, rt, rd   out  5   register addresses to datapath
//   SEin         out  16  immediate to sign-extender
//   FuncCode     out  4   ALU function (funct[3:0])
//   Regsel       out  1   write-register select: 1 = rd, 0 = rt
//   ALUsel       out  1   ALU operand B select: 1 = register rt, 0 = sign-extended SEin
//   ALUOp        out  2   00 add, 01 subtract, 10 use FuncCode
//   MemWrite     out  1   data-memory write strobe
//   MemRead      out  1   data-memory read enable
//   MemToRegSel  out  1   writeback source: 1 = memory, 0 = ALU
//   RegWrite     out  1   register-file write strobe
//   branch_taken out  1   one-cycle pulse: beq resolved taken
//   instr_done   out  1   one-cycle pulse in final state of each instruction
//   illegal      out  1   one-cycle pulse: unsupported opcode
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; every output 0 except instr_ready=1.
//     Strobes drop immediately on rst_n low; no write is completed after reset.
//   - States: IDLE, DECODE, EXEC, MEM, WB.
//     All outputs are registered Moore outputs, valid for the whole state cycle.
//   - instr_ready=1 only in IDLE. Accept occurs on an edge with instr_valid & instr_ready.
//     On accept: rs, rt, rd, SEin, FuncCode are latched and held stable until the next accept.
//   - IDLE -> DECODE on accept. DECODE -> EXEC always, or -> IDLE with illegal=1 if opcode unsupported.
//   - Opcode table (selects valid DECODE..last state, cleared to 0 on return to IDLE):
//       0x00 R-type: Regsel=1 ALUsel=1 ALUOp=10 MemToRegSel=0; EXEC -> WB -> IDLE
//       0x08 addi:   Regsel=0 ALUsel=0 ALUOp=00 MemToRegSel=0; EXEC -> WB -> IDLE
//       0x23 lw:     Regsel=0 ALUsel=0 ALUOp=00 MemToRegSel=1; EXEC -> MEM -> WB -> IDLE
//       0x2B sw:     ALUsel=0 ALUOp=00; EXEC -> MEM -> IDLE
//       0x04 beq:    ALUsel=1 ALUOp=01; EXEC -> IDLE
//   - RegWrite=1 only in WB (exactly one cycle).
//   - MemRead=1 for all MEM cycles of lw; MemWrite=1 for all MEM cycles of sw; both 0 elsewhere.
//   - MEM lasts exactly MEM_WAIT cycles, using a 4-bit down-counter loaded on entry.
//   - beq samples Zero on the EXEC edge. branch_taken=1 for the following cycle (IDLE) iff Zero=1.
//   - instr_done pulses in the last non-IDLE state: WB, sw MEM final cycle, or beq EXEC.
//     It does not pulse for illegal opcodes.
//   - Latency, accept edge to instr_done cycle:
//       R/addi: 3 cycles; lw: 3+MEM_WAIT; sw: 2+MEM_WAIT; beq: 2.
//   - FuncCode is driven for every opcode but is only meaningful with ALUOp=10.
//   - instr_valid while busy is ignored: no accept, and latched fields do not change.
//   - Back-to-back: a new accept may occur in the IDLE cycle carrying branch_taken.
// TESTING
//   1 Reset: rst_n=0 mid-lw MEM -> MemRead, RegWrite, state all 0 within the same cycle; instr_ready=1 after release.
//   2 R-type add rs=1 rt=2 rd=5 funct=0x20 -> FuncCode=0000, ALUOp=10, Regsel=1; RegWrite pulses exactly 3 cycles after accept.
//   3 R-type sweep funct 0x22/0x24/0x25/0x2A -> FuncCode 0010/0100/0101/1010, one RegWrite each, no MemWrite.
//   4 lw rt=10 imm=0x0028, MEM_WAIT=3 -> MemRead high 3 cycles, then RegWrite=1 with MemToRegSel=1, Regsel=0, SEin=0x0028.
//   5 sw imm=0x0014 -> MemWrite high MEM_WAIT cycles, RegWrite never asserted.
//     beq with Zero=1 -> branch_taken one cycle; with Zero=0 -> never.
//   6 opcode 0x3F -> illegal pulse, no strobes, back in IDLE after 2 cycles.
//     instr_valid held during busy -> fields unchanged, single accept.

Source files
------------

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer for the FullDMRFALU datapath.
// Accepts one instruction at a time and steps it through DECODE/EXEC/MEM/WB with registered Moore outputs.
module mc_ctrl_seq #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        Zero,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] SEin,
    output logic [3:0]  FuncCode,
    output logic        Regsel,
    output logic        ALUsel,
    output logic [1:0]  ALUOp,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToRegSel,
    output logic        RegWrite,
    output logic        branch_taken,
    output logic        instr_done,
    output logic        illegal,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_BAD, C_R, C_ADDI, C_LW, C_SW, C_BEQ} cls_t;

    localparam logic [3:0] MEM_CNT_INIT = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept, live;
    logic       ready_d, regsel_d, alusel_d, memwrite_d, memread_d, memtoreg_d;
    logic       regwrite_d, branch_d, done_d, illegal_d;
    logic [1:0] aluop_d;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'h00:   return C_R;
            6'h08:   return C_ADDI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            default: return C_BAD;
        endcase
    endfunction

    // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
    // instr_ready is high exactly in IDLE, and valid while busy is simply ignored.
    assign accept    = (state_q == S_IDLE) && instr_valid;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DECODE;
                    cls_d   = classify(instr[31:26]);
                end
            end
            S_DECODE: state_d = (cls_q == C_BAD) ? S_IDLE : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_LW, C_SW: begin
                        state_d = S_MEM;
                        cnt_d   = MEM_CNT_INIT;
                    end
                    C_BEQ:   state_d = S_IDLE;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (cnt_q == 4'd0) state_d = (cls_q == C_LW) ? S_WB : S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed for the state being entered, then registered.
        live        = (state_d != S_IDLE);
        ready_d     = !live;
        regsel_d    = live && (cls_d == C_R);
        alusel_d    = live && ((cls_d == C_R) || (cls_d == C_BEQ));
        aluop_d     = 2'b00;
        if (live && cls_d == C_R)   aluop_d = 2'b10;
        if (live && cls_d == C_BEQ) aluop_d = 2'b01;
        memtoreg_d  = live && (cls_d == C_LW);
        memread_d   = (state_d == S_MEM) && (cls_d == C_LW);
        memwrite_d  = (state_d == S_MEM) && (cls_d == C_SW);
        regwrite_d  = (state_d == S_WB);
        branch_d    = (state_q == S_EXEC) && (cls_q == C_BEQ) && Zero;
        illegal_d   = (state_q == S_DECODE) && (cls_q == C_BAD);
        done_d      = (state_d == S_WB)
                   || ((state_d == S_MEM) && (cls_d == C_SW) && (cnt_d == 4'd0))
                   || ((state_d == S_EXEC) && (cls_d == C_BEQ));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cls_q        <= C_BAD;
            cnt_q        <= '0;
            instr_ready  <= 1'b1;
            rs           <= '0;
            rt           <= '0;
            rd           <= '0;
            SEin         <= '0;
            FuncCode     <= '0;
            Regsel       <= 1'b0;
            ALUsel       <= 1'b0;
            ALUOp        <= 2'b00;
            MemWrite     <= 1'b0;
            MemRead      <= 1'b0;
            MemToRegSel  <= 1'b0;
            RegWrite     <= 1'b0;
            branch_taken <= 1'b0;
            instr_done   <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            cnt_q        <= cnt_d;
            instr_ready  <= ready_d;
            Regsel       <= regsel_d;
            ALUsel       <= alusel_d;
            ALUOp        <= aluop_d;
            MemWrite     <= memwrite_d;
            MemRead      <= memread_d;
            MemToRegSel  <= memtoreg_d;
            RegWrite     <= regwrite_d;
            branch_taken <= branch_d;
            instr_done   <= done_d;
            illegal      <= illegal_d;
            if (accept) begin
                rs       <= instr[25:21];
                rt       <= instr[20:16];
                rd       <= instr[15:11];
                SEin     <= instr[15:0];
                FuncCode <= instr[3:0];
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Self-checking bench for mc_ctrl_seq: directed scenarios plus random instruction streams
// compared cycle by cycle against a latency-based reference model.
module tb_mc_ctrl_seq;

    localparam int W = 3;

    logic        clk, rst_n;
    logic [31:0] instr;
    logic        instr_valid, instr_ready, Zero;
    logic [4:0]  rs, rt, rd;
    logic [15:0] SEin;
    logic [3:0]  FuncCode;
    logic        Regsel, ALUsel, MemWrite, MemRead, MemToRegSel, RegWrite;
    logic        branch_taken, instr_done, illegal;
    logic [1:0]  ALUOp;
    logic [2:0]  state_dbg;

    typedef struct packed {
        logic        ready;
        logic [4:0]  rs, rt, rd;
        logic [15:0] sein;
        logic [3:0]  fc;
        logic        regsel, alusel;
        logic [1:0]  aluop;
        logic        memwrite, memread, memtoreg, regwrite, branch, done, illegal;
    } outv_t;

    outv_t obs;
    int    checks = 0;
    int    errors = 0;

    mc_ctrl_seq #(.MEM_WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Zero(Zero), .rs(rs), .rt(rt), .rd(rd),
        .SEin(SEin), .FuncCode(FuncCode), .Regsel(Regsel), .ALUsel(ALUsel),
        .ALUOp(ALUOp), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemToRegSel(MemToRegSel), .RegWrite(RegWrite), .branch_taken(branch_taken),
        .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
    );

    assign obs = {instr_ready, rs, rt, rd, SEin, FuncCode, Regsel, ALUsel, ALUOp,
                  MemWrite, MemRead, MemToRegSel, RegWrite, branch_taken, instr_done, illegal};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Number of busy cycles from the accept edge to the final state (illegal: DECODE only).
    function automatic int lat(input logic [31:0] iw);
        case (iw[31:26])
            6'h00, 6'h08: return 3;
            6'h23:        return 3 + W;
            6'h2B:        return 2 + W;
            6'h04:        return 2;
            default:      return 1;
        endcase
    endfunction

    // Expected outputs in the k-th cycle after the accept edge (k=1 is the first cycle).
    function automatic outv_t model(input logic [31:0] iw, input logic z, input int k);
        outv_t      o;
        logic [5:0] op;
        int         l;
        logic       bad;
        op  = iw[31:26];
        l   = lat(iw);
        bad = !(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04});
        o = '0;
        o.rs = iw[25:21]; o.rt = iw[20:16]; o.rd = iw[15:11];
        o.sein = iw[15:0]; o.fc = iw[3:0];
        if (k > l) begin
            o.ready = 1'b1;
            if (k == l + 1) begin
                o.branch  = (op == 6'h04) && z;
                o.illegal = bad;
            end
            return o;
        end
        if (bad) return o;
        o.done = (k == l);
        case (op)
            6'h00: begin o.regsel = 1; o.alusel = 1; o.aluop = 2'b10; o.regwrite = (k == l); end
            6'h08: begin o.regwrite = (k == l); end
            6'h23: begin o.memtoreg = 1; o.memread = (k >= 3 && k <= 2 + W); o.regwrite = (k == l); end
            6'h2B: begin o.memwrite = (k >= 3 && k <= 2 + W); end
            6'h04: begin o.alusel = 1; o.aluop = 2'b01; end
            default: ;
        endcase
        return o;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] iw, input logic z, input logic hold);
        instr = iw; Zero = z; instr_valid = 1'b1;
        step();
        if (!hold) instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        outv_t       r;
        logic [31:0] iw;
        r = '0; r.ready = 1'b1;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; Zero = 1'b0;
        #12;
        checks++;
        if (obs !== r || state_dbg !== 3'd0) begin
            $display("FAIL reset_initial got %h/%0d exp %h/0", obs, state_dbg, r); errors++;
        end
        @(negedge clk); rst_n = 1'b1;
        step();
        checks++;
        if (obs !== r) begin $display("FAIL reset_release got %h exp %h", obs, r); errors++; end
        // Interrupt a lw in its first MEM cycle.
        iw = itype(6'h23, 5'd3, 5'd10, 16'h0028);
        send(iw, 1'b0, 1'b0);
        step(); step();
        checks++;
        if (MemRead !== 1'b1) begin $display("FAIL reset_pre_mem got %b exp 1", MemRead); errors++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== r || state_dbg !== 3'd0) begin
            $display("FAIL reset_mid_mem got %h/%0d exp %h/0", obs, state_dbg, r); errors++;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== r) begin $display("FAIL reset_after i=%0d got %h exp %h", i, obs, r); errors++; end
        end
    endtask

    task automatic test_rtype_add();
        logic [31:0] iw;
        outv_t       e;
        int          l;
        iw = rtype(5'd1, 5'd2, 5'd5, 6'h20);
        l  = lat(iw);
        send(iw, 1'b0, 1'b0);
        for (int k = 1; k <= l + 1; k++) begin
            e = model(iw, 1'b0, k);
            checks++;
            if (obs !== e) begin $display("FAIL rtype_add k=%0d got %h exp %h", k, obs, e); errors++; end
            checks++;
            if (RegWrite !== (k == 3)) begin $display("FAIL rtype_add_regwrite k=%0d got %b exp %b", k, RegWrite, k == 3); errors++; end
            if (k <= l) step();
        end
    endtask

    task automatic test_rtype_sweep();
        logic [5:0]  f[4];
        logic [3:0]  fc_exp[4];
        logic [31:0] iw;
        outv_t       e;
        int          nwr;
        f = '{6'h22, 6'h24, 6'h25, 6'h2A};
        fc_exp = '{4'b0010, 4'b0100, 4'b0101, 4'b1010};
        for (int n = 0; n < 4; n++) begin
            iw = rtype(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)), f[n]);
            send(iw, 1'b0, 1'b0);
            nwr = 0;
            for (int k = 1; k <= lat(iw) + 1; k++) begin
                e = model(iw, 1'b0, k);
                checks++;
                if (obs !== e) begin $display("FAIL rsweep n=%0d k=%0d got %h exp %h", n, k, obs, e); errors++; end
                if (RegWrite === 1'b1) nwr++;
                if (k <= lat(iw)) step();
            end
            checks++;
            if (nwr != 1 || FuncCode !== fc_exp[n]) begin
                $display("FAIL rsweep_sum n=%0d writes=%0d fc=%b exp 1/%b", n, nwr, FuncCode, fc_exp[n]); errors++;
            end
        end
    endtask

    task automatic test_lw();
        logic [31:0] iw;
        outv_t       e;
        int          nrd;
        iw = itype(6'h23, 5'd4, 5'd10, 16'h0028);
        send(iw, 1'b0, 1'b0);
        nrd = 0;
        for (int k = 1; k <= lat(iw) + 1; k++) begin
            e = model(iw, 1'b0, k);
            checks++;
            if (obs !== e) begin $display("FAIL lw k=%0d got %h exp %h", k, obs, e); errors++; end
            if (MemRead === 1'b1) nrd++;
            if (k == lat(iw)) begin
                checks++;
                if (!(RegWrite && MemToRegSel && !Regsel && SEin == 16'h0028 && rt == 5'd10)) begin
                    $display("FAIL lw_wb got rw=%b m2r=%b rsel=%b sein=%h exp 1 1 0 0028", RegWrite, MemToRegSel, Regsel, SEin); errors++;
                end
            end
            if (k <= lat(iw)) step();
        end
        checks++;
        if (nrd != W) begin $display("FAIL lw_memread_cycles got %0d exp %0d", nrd, W); errors++; end
    endtask

    task automatic test_sw_beq();
        logic [31:0] iw[3];
        logic        z[3];
        outv_t       e;
        int          nmw, nbr;
        iw = '{itype(6'h2B, 5'd7, 5'd9, 16'h0014), itype(6'h04, 5'd2, 5'd3, 16'hFFFC),
               itype(6'h04, 5'd2, 5'd3, 16'h0008)};
        z  = '{1'b1, 1'b1, 1'b0};
        for (int n = 0; n < 3; n++) begin
            send(iw[n], z[n], 1'b0);
            nmw = 0; nbr = 0;
            for (int k = 1; k <= lat(iw[n]) + 1; k++) begin
                e = model(iw[n], z[n], k);
                checks++;
                if (obs !== e) begin $display("FAIL sw_beq n=%0d k=%0d got %h exp %h", n, k, obs, e); errors++; end
                if (MemWrite === 1'b1) nmw++;
                if (branch_taken === 1'b1) nbr++;
                if (k <= lat(iw[n])) step();
            end
            checks++;
            if (nmw != (n == 0 ? W : 0) || nbr != (n == 1 ? 1 : 0)) begin
                $display("FAIL sw_beq_sum n=%0d memwrite=%0d branch=%0d", n, nmw, nbr); errors++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] iw;
        outv_t       e;
        iw = itype(6'h3F, 5'd1, 5'd2, 16'h1234);
        send(iw, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            e = model(iw, 1'b1, k);
            checks++;
            if (obs !== e) begin $display("FAIL illegal k=%0d got %h exp %h", k, obs, e); errors++; end
            if (k < 3) step();
        end
    endtask

    task automatic test_busy_ignored();
        logic [31:0] iw;
        outv_t       e;
        int          l;
        iw = itype(6'h23, 5'd17, 5'd18, 16'h00F0);
        l  = lat(iw);
        send(iw, 1'b0, 1'b1);
        for (int k = 1; k <= l + 2; k++) begin
            instr = $urandom;
            e = model(iw, 1'b0, k);
            checks++;
            if (obs !== e) begin $display("FAIL busy k=%0d got %h exp %h", k, obs, e); errors++; end
            if (k == l + 1) instr_valid = 1'b0;
            if (k <= l + 1) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] iw[6];
        logic        z[6];
        outv_t       e;
        iw = '{itype(6'h04, 5'd1, 5'd1, 16'h0004), rtype(5'd3, 5'd4, 5'd6, 6'h25),
               itype(6'h04, 5'd1, 5'd2, 16'h0010), itype(6'h23, 5'd8, 5'd9, 16'h0100),
               itype(6'h2B, 5'd8, 5'd9, 16'h0104), itype(6'h08, 5'd5, 5'd6, 16'h8001)};
        z  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int n = 0; n < 6; n++) begin
            send(iw[n], z[n], 1'b0);
            for (int k = 1; k <= lat(iw[n]) + 1; k++) begin
                e = model(iw[n], z[n], k);
                checks++;
                if (obs !== e) begin $display("FAIL b2b n=%0d k=%0d got %h exp %h", n, k, obs, e); errors++; end
                if (k <= lat(iw[n])) step();
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops[6];
        logic [31:0] iw;
        logic        z;
        outv_t       e;
        int          l, gap;
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h3F};
        for (int n = 0; n < 40; n++) begin
            iw = $urandom;
            iw[31:26] = ops[$urandom_range(5)];
            if (iw[31:26] == 6'h3F) iw[31:26] = 6'($urandom_range(63));
            z   = 1'($urandom_range(1));
            l   = lat(iw);
            gap = $urandom_range(2);
            send(iw, z, 1'b0);
            for (int k = 1; k <= l + 1 + gap; k++) begin
                e = model(iw, z, k);
                checks++;
                if (obs !== e) begin $display("FAIL random n=%0d op=%h k=%0d got %h exp %h", n, iw[31:26], k, obs, e); errors++; end
                if (k <= l + gap) step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_rtype_sweep();
        test_lw();
        test_sw_beq();
        test_illegal();
        test_busy_ignored();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
